// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: opcodes plus the 2-bit branch-counter encoding
// used by the direction predictors.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic [1:0] {
    strong_nt = 2'b00,
    weak_nt   = 2'b01,
    weak_t    = 2'b10,
    strong_t  = 2'b11
  } pht_ctr_t;

  localparam pht_ctr_t PHT_INIT = weak_nt;

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch/EX-MEM side bundle of the gshare predictor. The pipeline is the master,
// the predictor is the slave.
interface gshare_predictor_if #(
  parameter int GHR_WIDTH = 8,
  parameter int IDX_WIDTH = 8
);
  logic                 stall;
  logic [31:0]          if_pc;
  logic                 gl_br_dir;
  logic [IDX_WIDTH-1:0] gl_pht_idx;
  logic [IDX_WIDTH-1:0] ex_mem_pht_idx;
  logic                 ex_mem_br_en;
  logic [6:0]           ex_mem_opcode;
  logic [GHR_WIDTH-1:0] ghr;

  modport master (
    output stall, if_pc, ex_mem_pht_idx, ex_mem_br_en, ex_mem_opcode,
    input  gl_br_dir, gl_pht_idx, ghr
  );

  modport slave (
    input  stall, if_pc, ex_mem_pht_idx, ex_mem_br_en, ex_mem_opcode,
    output gl_br_dir, gl_pht_idx, ghr
  );
endinterface

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter; shared by the
// global and local predictors.
module sat_counter2
  import rv32i_types::*;
(
  input  pht_ctr_t ctr_i,
  input  logic     taken_i,
  output pht_ctr_t ctr_o
);

  always_comb begin
    // NOTE: assigning a default before any branch keeps always_comb free of
    // inferred latches when a path leaves the output untouched.
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != strong_t) ctr_o = pht_ctr_t'(ctr_i + 2'd1);
    end else begin
      if (ctr_i != strong_nt) ctr_o = pht_ctr_t'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PHT of 2-bit counters indexed by PC ^ GHR,
// trained non-speculatively from EX/MEM.
module gshare_predictor
  import rv32i_types::*;
#(
  parameter int GHR_WIDTH = 8,
  parameter int IDX_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  gshare_predictor_if.slave bp
);

  localparam int PHT_DEPTH = 2 ** IDX_WIDTH;

  pht_ctr_t             pht_q [PHT_DEPTH];
  pht_ctr_t             pht_d [PHT_DEPTH];
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic [IDX_WIDTH-1:0] fetch_idx;
  logic [1:0]           rd_ctr;
  pht_ctr_t             wr_ctr;
  logic                 train;
  logic                 unused_pc_bits;

  assign train     = !bp.stall && (bp.ex_mem_opcode == op_br);
  assign fetch_idx = bp.if_pc[IDX_WIDTH+1:2] ^ IDX_WIDTH'(ghr_q);

  // Read sees the registered array only, so a same-cycle write is not bypassed.
  assign rd_ctr        = pht_q[fetch_idx];
  assign bp.gl_br_dir  = rd_ctr[1];
  assign bp.gl_pht_idx = fetch_idx;
  assign bp.ghr        = ghr_q;

  assign unused_pc_bits = ^{bp.if_pc[31:IDX_WIDTH+2], bp.if_pc[1:0]};

  sat_counter2 u_ctr (
    .ctr_i  (pht_q[bp.ex_mem_pht_idx]),
    .taken_i(bp.ex_mem_br_en),
    .ctr_o  (wr_ctr)
  );

  always_comb begin
    pht_d = pht_q;
    ghr_d = ghr_q;
    if (train) begin
      pht_d[bp.ex_mem_pht_idx] = wr_ctr;
      ghr_d = GHR_WIDTH'({ghr_q, bp.ex_mem_br_en});
    end
  end

  // NOTE: the PHT is a flop array, not SRAM, so every entry can and must take
  // its reset value; state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= PHT_INIT;
      ghr_q <= '0;
    end else begin
      pht_q <= pht_d;
      ghr_q <= ghr_d;
    end
  end

endmodule
